// File: rtl/decode_queue.sv
// Decode-and-queue stage between fetch and issue: classifies up to IW instructions
// per cycle and buffers them in a DEPTH-entry circular queue popped by issue.
module decode_queue #(
  parameter int unsigned IW    = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic [IW-1:0]             in_valid,
  input  logic [32*IW-1:0]          in_pc,
  input  logic [32*IW-1:0]          in_inst,
  output logic                      in_ready,
  output logic [IW-1:0]             out_valid,
  output logic [32*IW-1:0]          out_pc,
  output logic [32*IW-1:0]          out_inst,
  output logic [3*IW-1:0]           out_type,
  output logic [IW-1:0]             out_ine,
  input  logic [$clog2(IW+1)-1:0]   pop_num
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] T_ALU    = 3'd0;
  localparam logic [2:0] T_BR     = 3'd1;
  localparam logic [2:0] T_DIV    = 3'd2;
  localparam logic [2:0] T_PRIV   = 3'd3;
  localparam logic [2:0] T_MUL    = 3'd4;
  localparam logic [2:0] T_DCACHE = 3'd5;
  localparam logic [2:0] T_LLSC   = 3'd6;

  // Returns {ine, type}; unrecognised encodings report priv with ine set.
  function automatic logic [3:0] decode_inst(input logic [31:0] inst);
    logic [5:0]  op;
    logic [3:0]  f4;
    logic [6:0]  f7;
    logic [10:0] f11;
    logic [2:0]  ty;
    logic        ok;
    op  = inst[31:26];
    f4  = inst[25:22];
    f7  = inst[21:15];
    f11 = inst[25:15];
    ty  = T_PRIV;
    ok  = 1'b1;
    if (op == 6'b000000) begin
      if (f4 == 4'b0000 && (f7 inside {7'h20, 7'h22, 7'h24, 7'h25, 7'h28, 7'h29,
                                       7'h2A, 7'h2B, 7'h2E, 7'h2F, 7'h30}))
        ty = T_ALU;
      else if (f4 == 4'b0001 && inst[21:20] == 2'b00 && inst[17:15] == 3'b001 &&
               inst[19:18] != 2'b11)
        ty = T_ALU;
      else if (f4 inside {4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b1111})
        ty = T_ALU;
      else if (f11 >= 11'h038 && f11 <= 11'h03A)
        ty = T_MUL;
      else if (f11 >= 11'h040 && f11 <= 11'h043)
        ty = T_DIV;
      else if (f11 == 11'h054 || f11 == 11'h056)
        ty = T_PRIV;
      else
        ok = 1'b0;
    end else if (op == 6'b000001) begin
      if (inst[25:24] == 2'b00 || f4 == 4'b1000 || inst == 32'h0648_3800 ||
          inst[31:15] == 17'h00C91)
        ty = T_PRIV;
      else
        ok = 1'b0;
    end else if (op == 6'b000101 || op == 6'b000111) begin
      if (!inst[25]) ty = T_ALU;
      else           ok = 1'b0;
    end else if (op == 6'b001000) begin
      if (!inst[25]) ty = T_LLSC;
      else           ok = 1'b0;
    end else if (op == 6'b001010) begin
      if (f4 inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110,
                     4'b1000, 4'b1001, 4'b1011})
        ty = T_DCACHE;
      else
        ok = 1'b0;
    end else if (op == 6'b001110) begin
      if (inst[31:15] == 17'h070E5) ty = T_PRIV;
      else                          ok = 1'b0;
    end else if (op == 6'b010100 || (op >= 6'b010110 && op <= 6'b011011)) begin
      ty = T_BR;
    end else begin
      ok = 1'b0;
    end
    return {~ok, ok ? ty : T_PRIV};
  endfunction

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [2:0]    type_mem [DEPTH];
  logic          ine_mem  [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [3:0]    dec [IW];
  logic [CW-1:0] n_push;
  logic          push_fire;

  assign in_ready  = (count_q <= CW'(DEPTH - IW));
  assign push_fire = in_ready & in_valid[0] & ~flush;

  always_comb begin
    n_push = '0;
    for (int unsigned k = 0; k < IW; k++) begin
      dec[k] = decode_inst(in_inst[32*k +: 32]);
      n_push = n_push + CW'(in_valid[k]);
    end
  end

  // Flush drops any concurrent push/pop; occupancy uses the pre-pop count for in_ready.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_fire) tail_d = tail_q + n_push[AW-1:0];
      head_d  = head_q + AW'(pop_num);
      count_d = count_q + (push_fire ? n_push : '0) - CW'(pop_num);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; out_valid gates its visibility.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < IW; k++) begin
      if (push_fire && in_valid[k]) begin
        pc_mem  [tail_q + AW'(k)] <= in_pc  [32*k +: 32];
        inst_mem[tail_q + AW'(k)] <= in_inst[32*k +: 32];
        type_mem[tail_q + AW'(k)] <= dec[k][2:0];
        ine_mem [tail_q + AW'(k)] <= dec[k][3];
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_inst  = '0;
    out_type  = '0;
    out_ine   = '0;
    for (int unsigned k = 0; k < IW; k++) begin
      out_valid[k]         = (count_q > CW'(k));
      out_pc  [32*k +: 32] = pc_mem  [head_q + AW'(k)];
      out_inst[32*k +: 32] = inst_mem[head_q + AW'(k)];
      out_type[3*k +: 3]   = type_mem[head_q + AW'(k)];
      out_ine [k]          = ine_mem [head_q + AW'(k)];
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: a pattern-table decode model and an entry queue are
// compared against the DUT every cycle, plus directed literal checks.
module tb_decode_queue;
  localparam int unsigned IW    = 2;
  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rstn, flush;
  logic [IW-1:0]     in_valid;
  logic [32*IW-1:0]  in_pc, in_inst;
  logic              in_ready;
  logic [IW-1:0]     out_valid;
  logic [32*IW-1:0]  out_pc, out_inst;
  logic [3*IW-1:0]   out_type;
  logic [IW-1:0]     out_ine;
  logic [1:0]        pop_num;

  always #5 clk = ~clk;

  decode_queue #(.IW(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_type(out_type), .out_ine(out_ine), .pop_num(pop_num)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] mask; logic [31:0] match; logic [2:0] ty; } pat_t;

  ent_t        mq[$];
  pat_t        pats[$];
  int          passes = 0;
  int          total  = 0;
  bit          model_ok = 1'b0;
  int unsigned sz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic [31:0] mask, input logic [31:0] match, input logic [2:0] ty);
    pats.push_back('{mask, match, ty});
  endtask

  // First matching pattern wins; no match means illegal, reported as priv.
  function automatic logic [3:0] classify(input logic [31:0] inst);
    foreach (pats[i])
      if ((inst & pats[i].mask) == pats[i].match) return {1'b0, pats[i].ty};
    return 4'b1011;
  endfunction

  task automatic build_patterns();
    logic [6:0]  alu7[11] = '{7'h20, 7'h22, 7'h24, 7'h25, 7'h28, 7'h29, 7'h2A, 7'h2B, 7'h2E, 7'h2F, 7'h30};
    logic [3:0]  alu4[6]  = '{4'h8, 4'h9, 4'hA, 4'hD, 4'hE, 4'hF};
    logic [3:0]  dc4[9]   = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hB};
    foreach (alu7[i]) add(32'hFFFF_8000, {17'd0, alu7[i], 15'd0} , 3'd0);
    for (int b = 0; b < 3; b++) add(32'hFFFF_8000, 32'h0040_8000 | (32'(b) << 18), 3'd0);
    foreach (alu4[i]) add(32'hFFC0_0000, {6'd0, alu4[i], 22'd0}, 3'd0);
    add(32'hFE00_0000, 32'h1400_0000, 3'd0);
    add(32'hFE00_0000, 32'h1C00_0000, 3'd0);
    for (int v = 'h38; v <= 'h3A; v++) add(32'hFFFF_8000, 32'(v) << 15, 3'd4);
    for (int v = 'h40; v <= 'h43; v++) add(32'hFFFF_8000, 32'(v) << 15, 3'd2);
    add(32'hFFFF_8000, 32'h002A_0000, 3'd3);
    add(32'hFFFF_8000, 32'h002B_0000, 3'd3);
    add(32'hFF00_0000, 32'h0400_0000, 3'd3);
    add(32'hFFC0_0000, 32'h0600_0000, 3'd3);
    add(32'hFFFF_FFFF, 32'h0648_3800, 3'd3);
    add(32'hFFFF_8000, 32'h0648_8000, 3'd3);
    add(32'hFFFF_8000, 32'h3872_8000, 3'd3);
    add(32'hFE00_0000, 32'h2000_0000, 3'd6);
    foreach (dc4[i]) add(32'hFFC0_0000, 32'h2800_0000 | {6'd0, dc4[i], 22'd0}, 3'd5);
    add(32'hFC00_0000, 32'h5000_0000, 3'd1);
    for (int o = 'h16; o <= 'h1B; o++) add(32'hFC00_0000, 32'(o) << 26, 3'd1);
  endtask

  // Model state advances at the same edge as the DUT.
  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (flush) mq.delete();
      else begin
        sz = mq.size();
        for (int i = 0; i < int'(pop_num); i++)
          if (mq.size() > 0) void'(mq.pop_front());
        if ((DEPTH - sz >= IW) && in_valid[0])
          for (int k = 0; k < IW; k++)
            if (in_valid[k]) mq.push_back('{in_pc[32*k +: 32], in_inst[32*k +: 32]});
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("in_ready", in_ready, (DEPTH - mq.size()) >= IW);
      for (int k = 0; k < IW; k++) begin
        chk($sformatf("out_valid%0d", k), out_valid[k], mq.size() > k);
        if (mq.size() > k) begin
          chk($sformatf("out_pc%0d", k),   out_pc[32*k +: 32],   mq[k].pc);
          chk($sformatf("out_inst%0d", k), out_inst[32*k +: 32], mq[k].inst);
          chk($sformatf("ine_type%0d", k), {out_ine[k], out_type[3*k +: 3]}, classify(mq[k].inst));
        end
      end
      if (rstn && !flush && int'(pop_num) > $countones(out_valid)) begin
        total++;
        $display("FAIL pop_legal: pop_num %0d exceeds valid count %0d", pop_num, $countones(out_valid));
      end
    end
  end

  task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                      input logic [31:0] p1, input logic [31:0] i1, input int pop,
                      input bit fl, input bit rs);
    in_valid = v;
    in_pc    = {p1, p0};
    in_inst  = {i1, i0};
    pop_num  = 2'(pop);
    flush    = fl;
    rstn     = rs;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mix[28] = '{
    32'h00100C41, 32'h58000000, 32'h00200000, 32'hFFFFFFFF, 32'h28800000, 32'h001C0000,
    32'h002A0000, 32'h002B0000, 32'h04000000, 32'h06483800, 32'h06488000, 32'h38728000,
    32'h20000000, 32'h21000000, 32'h02000000, 32'h14000000, 32'h1C000000, 32'h16000000,
    32'h50000000, 32'h6C000000, 32'h54000000, 32'h2A000000, 32'h28C00000, 32'h00408000,
    32'h004C8000, 32'h00218000, 32'h00220000, 32'h06000000};

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    build_patterns();
    chk("pin_add",  classify(32'h00100C41), 4'h0);
    chk("pin_beq",  classify(32'h58000000), 4'h1);
    chk("pin_div",  classify(32'h00200000), 4'h2);
    chk("pin_ill",  classify(32'hFFFFFFFF), 4'hB);
    chk("pin_ldw",  classify(32'h28800000), 4'h5);
    chk("pin_ill2", classify(32'h004C8000), 4'hB);

    step(2'b00, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    step(2'b00, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    chk("rst_valid", out_valid, 2'b00);
    chk("rst_ready", in_ready, 1'b1);
    step(2'b00, 0, 0, 0, 0, 0, 1'b0, 1'b1);

    step(2'b11, 32'h1000, 32'h00100C41, 32'h1004, 32'h58000000, 0, 1'b0, 1'b1);
    chk("t1_valid", out_valid, 2'b11);
    chk("t1_type",  out_type, 6'b001_000);
    chk("t1_ine",   out_ine, 2'b00);

    step(2'b11, 32'h1008, 32'h00200000, 32'h100C, 32'hFFFFFFFF, 2, 1'b0, 1'b1);
    chk("t2_type", out_type, 6'b011_010);
    chk("t2_ine",  out_ine, 2'b10);
    chk("t2_pc",   out_pc[31:0], 32'h1008);
    step(2'b01, 32'h1010, 32'h28800000, 0, 0, 2, 1'b0, 1'b1);
    chk("t2_ld_valid", out_valid, 2'b01);
    chk("t2_ld_type",  out_type[2:0], 3'd5);
    chk("t2_ld_ine",   out_ine[0], 1'b0);
    step(2'b00, 0, 0, 0, 0, 1, 1'b0, 1'b1);

    for (int j = 0; j < 4; j++) begin
      step(2'b11, 32'h2000 + 32'(8*j), mix[2*j], 32'h2004 + 32'(8*j), mix[2*j+1], 0, 1'b0, 1'b1);
      chk($sformatf("t3_ready%0d", j), in_ready, j < 3);
    end
    step(2'b11, 32'h3000, mix[8], 32'h3004, mix[9], 0, 1'b0, 1'b1);
    chk("t3_full_ready", in_ready, 1'b0);
    chk("t3_full_pc", out_pc[31:0], 32'h2000);

    step(2'b11, 32'h3100, mix[10], 32'h3104, mix[11], 2, 1'b0, 1'b1);
    chk("t4_ready", in_ready, 1'b1);
    chk("t4_pc", out_pc[31:0], 32'h2008);
    step(2'b11, 32'h3200, mix[12], 32'h3204, mix[13], 0, 1'b0, 1'b1);
    chk("t4_full", in_ready, 1'b0);
    for (int j = 0; j < 3; j++) step(2'b00, 0, 0, 0, 0, 2, 1'b0, 1'b1);
    chk("t4_wrap_pc", out_pc[31:0], 32'h3200);
    step(2'b00, 0, 0, 0, 0, 2, 1'b0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      p = (mq.size() >= 2) ? 2 : mq.size();
      if (i % 3 == 0 && p > 1) p = 1;
      step(2'b11, 32'h4000 + 32'(8*i), mix[2*i], 32'h4004 + 32'(8*i), mix[(2*i+1) % 28], p, 1'b0, 1'b1);
    end
    while (mq.size() > 0) step(2'b00, 0, 0, 0, 0, (mq.size() >= 2) ? 2 : 1, 1'b0, 1'b1);

    step(2'b11, 32'h5000, mix[0], 32'h5004, mix[1], 0, 1'b0, 1'b1);
    step(2'b11, 32'h5008, mix[2], 32'h500C, mix[3], 0, 1'b0, 1'b1);
    step(2'b01, 32'h5010, mix[4], 0, 0, 0, 1'b0, 1'b1);
    step(2'b11, 32'h5100, mix[5], 32'h5104, mix[6], 1, 1'b1, 1'b1);
    chk("t5_valid", out_valid, 2'b00);
    chk("t5_ready", in_ready, 1'b1);
    step(2'b01, 32'h5200, mix[7], 0, 0, 0, 1'b0, 1'b1);
    chk("t5_after_pc", out_pc[31:0], 32'h5200);
    step(2'b00, 0, 0, 0, 0, 1, 1'b0, 1'b1);

    step(2'b11, 32'h6000, mix[8], 32'h6004, mix[9], 0, 1'b0, 1'b1);
    step(2'b01, 32'h6008, mix[10], 0, 0, 0, 1'b0, 1'b1);
    step(2'b11, 32'h6100, mix[11], 32'h6104, mix[12], 0, 1'b0, 1'b0);
    chk("t6_rst_valid", out_valid, 2'b00);
    step(2'b01, 32'hABCD0000, 32'h00100C41, 0, 0, 0, 1'b0, 1'b1);
    chk("t6_valid", out_valid, 2'b01);
    chk("t6_pc", out_pc[31:0], 32'hABCD0000);
    step(2'b00, 0, 0, 0, 0, 1, 1'b0, 1'b1);
    step(2'b00, 0, 0, 0, 0, 0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
